// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package sseg_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n = glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

    // Digit index width; a single-digit display still gets a 1-bit index.
    function automatic int IDX_W(input int num_digits);
        return (num_digits <= 1) ? 1 : $clog2(num_digits);
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Refresh slot counter and digit index for the scan driver.
// tick ends a digit slot; wrap ends the last digit's slot (end of frame).
module sseg_slot_timer
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic [IDX_W(NUM_DIGITS)-1:0] idx_o,
    output logic                        tick_o,
    output logic                        wrap_o
);

    localparam int IW = IDX_W(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    // Next count/index: advance the digit at the end of each slot.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        tick_o = (cnt_q == CW'(REFRESH_DIV - 1));
        wrap_o = tick_o && (idx_q == IW'(NUM_DIGITS - 1));
        if (tick_o) begin
            cnt_d = '0;
            idx_d = wrap_o ? '0 : idx_q + 1'b1;
        end
    end

    // Counter and index registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned double buffering.
// Optional leading-zero blanking: define SSEG_LZ_BLANK_EN.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [6:0]              sseg,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    DP,
    output logic                    frame_done
);

    localparam int IW = IDX_W(NUM_DIGITS);

    logic [IW-1:0] idx, idx_next;
    logic          tick, wrap;

    sseg_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .idx_o   (idx),
        .tick_o  (tick),
        .wrap_o  (wrap)
    );

    logic [4*NUM_DIGITS-1:0] stage_hex_q, stage_hex_d, shadow_hex_q, shadow_hex_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   stage_en_q, stage_en_d, shadow_en_q, shadow_en_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   en_eff;
    logic [6:0]              sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d, fd_q;

    // Index the outputs will show after this edge (mirrors the timer step).
    always_comb begin
        idx_next = idx;
        if (tick) idx_next = wrap ? '0 : idx + 1'b1;
    end

    // Stage on load; promote to shadow only at a frame wrap. A load landing on
    // the wrap goes straight to the shadow so no stale frame is shown.
    always_comb begin
        stage_hex_d  = stage_hex_q;
        stage_dp_d   = stage_dp_q;
        stage_en_d   = stage_en_q;
        shadow_hex_d = shadow_hex_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_en_d  = shadow_en_q;
        pending_d    = pending_q;
        if (load) begin
            stage_hex_d = hex_in;
            stage_dp_d  = dp_in;
            stage_en_d  = digit_en;
            pending_d   = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                shadow_hex_d = hex_in;
                shadow_dp_d  = dp_in;
                shadow_en_d  = digit_en;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                shadow_hex_d = stage_hex_q;
                shadow_dp_d  = stage_dp_q;
                shadow_en_d  = stage_en_q;
                pending_d    = 1'b0;
            end
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    // Keep a digit only if it or some higher digit is significant; digit 0 always kept.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        en_eff = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen = seen | (shadow_en_d[k] &
                           ((shadow_hex_d[4*k +: 4] != 4'h0) | shadow_dp_d[k]));
            en_eff[k] = shadow_en_d[k] & (seen | (k == 0));
        end
    end
`else
    // Every enabled digit is shown as-is.
    assign en_eff = shadow_en_d;
`endif

    // Decode the digit that will be lit after this edge.
    always_comb begin
        sseg_d = SEG_BLANK;
        an_d   = '1;
        dp_d   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((IW'(k) == idx_next) && en_eff[k]) begin
                sseg_d = hex_to_seg(shadow_hex_d[4*k +: 4]);
                an_d[k] = 1'b0;
                dp_d   = ~shadow_dp_d[k];
            end
        end
    end

    // Buffers and pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_hex_q  <= '0;
            stage_dp_q   <= '0;
            stage_en_q   <= '0;
            shadow_hex_q <= '0;
            shadow_dp_q  <= '0;
            shadow_en_q  <= '0;
            pending_q    <= 1'b0;
            sseg_q       <= SEG_BLANK;
            an_q         <= '1;
            dp_q         <= 1'b1;
            fd_q         <= 1'b0;
        end else begin
            stage_hex_q  <= stage_hex_d;
            stage_dp_q   <= stage_dp_d;
            stage_en_q   <= stage_en_d;
            shadow_hex_q <= shadow_hex_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_en_q  <= shadow_en_d;
            pending_q    <= pending_d;
            sseg_q       <= sseg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            fd_q         <= wrap;
        end
    end

    assign sseg       = sseg_q;
    assign AN         = an_q;
    assign DP         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver (4 digits, 4 clks per slot) against a time-based model.
module tb_sseg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   hex_in;
    logic [3:0]    dp_in, digit_en;
    logic          load;
    logic [6:0]    sseg;
    logic [3:0]    AN;
    logic          DP, frame_done;

    int total  = 0;
    int passed = 0;

    sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .sseg(sseg), .AN(AN), .DP(DP),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Reference model: t = clocks since reset; the digit shown is (t/RD)%ND and a
    // frame ends when t%FRAME == FRAME-1. Expected pins follow each posedge.
    int          t;
    bit          m_pend;
    logic [15:0] st_hex, sh_hex;
    logic [3:0]  st_dp, sh_dp, st_en, sh_en;
    logic [6:0]  e_sseg;
    logic [3:0]  e_an;
    logic        e_dp, e_fd;

    always @(posedge clk) begin : model
        bit w, lit;
        int d, msd;
        if (reset) begin
            t = 0; m_pend = 0;
            st_hex = 0; st_dp = 0; st_en = 0; sh_hex = 0; sh_dp = 0; sh_en = 0;
            e_sseg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            w = (t % FRAME == FRAME - 1);
            if (w && load) begin
                sh_hex = hex_in; sh_dp = dp_in; sh_en = digit_en; m_pend = 0;
            end else begin
                if (w && m_pend) begin
                    sh_hex = st_hex; sh_dp = st_dp; sh_en = st_en; m_pend = 0;
                end
                if (load) begin
                    st_hex = hex_in; st_dp = dp_in; st_en = digit_en; m_pend = 1;
                end
            end
            t++;
            d = (t / RD) % ND;
            e_fd = w;
`ifdef SSEG_LZ_BLANK_EN
            msd = 0;
            for (int k = 0; k < ND; k++)
                if (sh_en[k] && (((sh_hex >> (4*k)) & 16'hF) != 0 || sh_dp[k])) msd = k;
            lit = sh_en[d] && (d <= msd);
`else
            msd = ND - 1;
            lit = sh_en[d] && (d <= msd);
`endif
            e_sseg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
            if (lit) begin
                e_an[d] = 1'b0;
                e_sseg  = glyph(4'((sh_hex >> (4*d)) & 16'hF));
                e_dp    = ~sh_dp[d];
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); total++;
            if (sseg !== 7'h7F || AN !== 4'hF || DP !== 1'b1 || frame_done !== 1'b0)
                $display("FAIL reset_hold sseg=%h AN=%h DP=%b fd=%b want 7f f 1 0",
                         sseg, AN, DP, frame_done);
            else passed++;
        end
        reset = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk); total++;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd)
                $display("FAIL reset_blank t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
    endtask

    task automatic test_basic();
        hex_in = 16'h1234; dp_in = 4'b0010; digit_en = 4'hF; load = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk); load = 1'b0; total++;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd)
                $display("FAIL basic t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
    endtask

    task automatic test_double_load();
        for (int i = 0; i < FRAME + 2 && (t % FRAME) != 5; i++) @(negedge clk);
        hex_in = 16'hABCD; load = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk); total++;
            load = (i == 3);
            if (i == 3) hex_in = 16'h5678;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd ||
                sseg === 7'h08 || sseg === 7'h03)
                $display("FAIL double_load t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
        load = 1'b0;
    endtask

    task automatic test_load_on_wrap();
        for (int i = 0; i < FRAME + 2 && (t % FRAME) != FRAME - 1; i++) @(negedge clk);
        total++;
        if ((t % FRAME) != FRAME - 1) $display("FAIL wrap_align t=%0d want t%%16=15", t);
        else passed++;
        hex_in = 16'h00F0; dp_in = 4'b0000; digit_en = 4'hF; load = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk); load = 1'b0; total++;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd)
                $display("FAIL load_on_wrap t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
    endtask

    task automatic test_enable_and_reset();
        hex_in = 16'h1234; dp_in = 4'b1111; digit_en = 4'b0101; load = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk); load = 1'b0; total++;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd ||
                AN[1] !== 1'b1 || AN[3] !== 1'b1)
                $display("FAIL enable t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
        // Pending load then mid-slot reset: the staged data must be dropped.
        hex_in = 16'h8888; digit_en = 4'hF; load = 1'b1;
        @(negedge clk); load = 1'b0;
        for (int i = 0; i < RD + 1 && (t % RD) != 2; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; total++;
        if (sseg !== 7'h7F || AN !== 4'hF || DP !== 1'b1 || frame_done !== 1'b0)
            $display("FAIL mid_reset sseg=%h AN=%h DP=%b fd=%b want 7f f 1 0",
                     sseg, AN, DP, frame_done);
        else passed++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk); total++;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd)
                $display("FAIL post_reset t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40 * FRAME; i++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                hex_in   = 16'($urandom);
                dp_in    = 4'($urandom);
                digit_en = 4'($urandom);
            end
            @(negedge clk); total++;
            if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd)
                $display("FAIL random t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                         t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
            else passed++;
        end
        load = 1'b0;
    endtask

`ifdef SSEG_LZ_BLANK_EN
    task automatic test_lz();
        logic [15:0] pats [2];
        pats[0] = 16'h0070; pats[1] = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            hex_in = pats[p]; dp_in = 4'b0000; digit_en = 4'hF; load = 1'b1;
            for (int i = 0; i < 3 * FRAME; i++) begin
                @(negedge clk); load = 1'b0; total++;
                if (sseg !== e_sseg || AN !== e_an || DP !== e_dp || frame_done !== e_fd)
                    $display("FAIL lz t=%0d sseg=%h/%h AN=%h/%h DP=%b/%b fd=%b/%b",
                             t, sseg, e_sseg, AN, e_an, DP, e_dp, frame_done, e_fd);
                else passed++;
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0; digit_en = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_double_load();
        test_load_on_wrap();
        test_enable_and_reset();
`ifdef SSEG_LZ_BLANK_EN
        test_lz();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
